bin2bcd_seq: RTL



---
 rtl/bin2bcd_seq.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one iteration per clock).
// Valid/ready handshake on both sides; result held in DONE until accepted.
// Optional macro BIN2BCD_SIGNED_EN: treat bin_in_i as two's complement and
// report the sign separately; when undefined the input is unsigned and sign_o is 0.
module bin2bcd_seq #(
    parameter int unsigned BIN_WIDTH = 16,
    parameter int unsigned DIGITS    = 5,
    localparam int unsigned NDW      = $clog2(DIGITS + 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [BIN_WIDTH-1:0] bin_in_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [4*DIGITS-1:0]  bcd_out_o,
    output logic [NDW-1:0]       ndigits_o,
    output logic                 overflow_o,
    output logic                 sign_o
);

    localparam int unsigned BW  = 4 * DIGITS;
    localparam int unsigned SRW = BW + BIN_WIDTH;
    localparam int unsigned CW  = $clog2(BIN_WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e               state_q, state_d;
    logic [SRW-1:0]       sr_q, sr_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;
    logic [BW-1:0]        bcd_q, bcd_d;
    logic [NDW-1:0]       nd_q, nd_d;
    logic                 ovf_out_q, ovf_out_d;

    logic [SRW-1:0]       adj;
    logic [SRW-1:0]       shifted;
    logic                 ovf_next;
    logic [NDW-1:0]       nd_calc;
    logic [BIN_WIDTH-1:0] mag;

`ifdef BIN2BCD_SIGNED_EN
    logic sign_q, sign_d;
    logic sign_out_q, sign_out_d;
    logic neg_in;
`endif

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    // Next-state, datapath iteration and handshake outputs
    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        bcd_d       = bcd_q;
        nd_d        = nd_q;
        ovf_out_d   = ovf_out_q;
        in_ready_o  = (state_q == StIdle);
        out_valid_o = (state_q == StDone);

`ifdef BIN2BCD_SIGNED_EN
        sign_d     = sign_q;
        sign_out_d = sign_out_q;
        neg_in     = bin_in_i[BIN_WIDTH-1];
        // Unsigned negation: the most negative value maps onto its own magnitude.
        mag        = neg_in ? (~bin_in_i + 1'b1) : bin_in_i;
`else
        mag        = bin_in_i;
`endif

        // Add-3 correction on every BCD nybble >= 5, then shift left by one.
        adj = sr_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (sr_q[BIN_WIDTH + 4*i +: 4] >= 4'd5) begin
                adj[BIN_WIDTH + 4*i +: 4] = sr_q[BIN_WIDTH + 4*i +: 4] + 4'd3;
            end
        end
        shifted  = {adj[SRW-2:0], 1'b0};
        ovf_next = ovf_q | adj[SRW-1];

        // Significant digit count of the value after this iteration.
        nd_calc = NDW'(1);
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (shifted[BIN_WIDTH + 4*i +: 4] != 4'd0) nd_calc = NDW'(i + 1);
        end
        if (ovf_next) nd_calc = NDW'(DIGITS);

        case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    sr_d    = {{BW{1'b0}}, mag};
                    ovf_d   = 1'b0;
                    cnt_d   = CW'(BIN_WIDTH);
`ifdef BIN2BCD_SIGNED_EN
                    sign_d  = neg_in;
`endif
                    state_d = StShift;
                end
            end
            StShift: begin
                sr_d  = shifted;
                ovf_d = ovf_next;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    bcd_d      = shifted[SRW-1:BIN_WIDTH];
                    nd_d       = nd_calc;
                    ovf_out_d  = ovf_next;
`ifdef BIN2BCD_SIGNED_EN
                    sign_out_d = sign_q;
`endif
                    state_d    = StDone;
                end
            end
            StDone: begin
                if (out_ready_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Working registers and held result registers
    always_ff @(posedge clock) begin
        if (reset) begin
            sr_q      <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            bcd_q     <= '0;
            nd_q      <= NDW'(1);
            ovf_out_q <= 1'b0;
        end else begin
            sr_q      <= sr_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            bcd_q     <= bcd_d;
            nd_q      <= nd_d;
            ovf_out_q <= ovf_out_d;
        end
    end

`ifdef BIN2BCD_SIGNED_EN
    // Sign of the word in flight and of the held result
    always_ff @(posedge clock) begin
        if (reset) begin
            sign_q     <= 1'b0;
            sign_out_q <= 1'b0;
        end else begin
            sign_q     <= sign_d;
            sign_out_q <= sign_out_d;
        end
    end
    assign sign_o = sign_out_q;
`else
    assign sign_o = 1'b0;
`endif

    assign bcd_out_o  = bcd_q;
    assign ndigits_o  = nd_q;
    assign overflow_o = ovf_out_q;

endmodule
